// File: rtl/reg_mux.sv
`default_nettype none
// ============================================================================
//  Module   : reg_mux
//  Purpose  : Optional pipeline stage for DSP48A1 operand/result paths.
//             register=1 : clock-enabled D register with synchronous
//                          (or, for attribute compatibility, asynchronous)
//                          active-high reset to zero.
//             register=0 : zero-latency wire from D to Q.
//  Revision : 1.0  initial release
// ============================================================================
module reg_mux #(
  parameter int WIDTH    = 1,
  parameter int register = 1,
  parameter     TYPE     = "SYNC"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam logic c_ASYNC = (TYPE == "ASYNC");

  generate
    if (register != 0) begin : g_registered
      logic [WIDTH-1:0] q_q;
      logic [WIDTH-1:0] q_d;

      // Next-state: load D when enabled, otherwise hold.
      always_comb begin
        q_d = q_q;
        if (clk_en) begin
          q_d = D;
        end
      end

      if (c_ASYNC) begin : g_async_rst
        // Register with asynchronous clear; reset still dominates the enable.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q_q <= '0;
          end else begin
            q_q <= q_d;
          end
        end
      end else begin : g_sync_rst
        // Register with synchronous clear; reset wins over clk_en.
        always_ff @(posedge clk) begin
          if (rst) begin
            q_q <= '0;
          end else begin
            q_q <= q_d;
          end
        end
      end

      assign Q = q_q;
    end else begin : g_bypass
      // Clock, reset and enable are irrelevant here; fold them into a sink
      // so no storage or stray logic is implied.
      logic w_unused_bypass;
      assign w_unused_bypass = &{1'b0, clk, rst, clk_en};

      assign Q = D;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_mux
//  Purpose  : Directed self-checking bench for reg_mux in SYNC (1- and 8-bit),
//             bypass (18-bit) and ASYNC configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // SYNC, WIDTH=1
  logic       rst_s = 1'b0, en_s = 1'b0, d_s = 1'b0;
  logic       q_s;
  // SYNC, WIDTH=8
  logic       rst_w = 1'b0, en_w = 1'b0;
  logic [7:0] d_w = '0;
  logic [7:0] q_w;
  // Bypass, WIDTH=18
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic [17:0] d_b = '0;
  logic [17:0] q_b;
  // ASYNC, WIDTH=1
  logic       rst_a = 1'b0, en_a = 1'b0, d_a = 1'b0;
  logic       q_a;

  reg_mux #(.WIDTH(1), .register(1), .TYPE("SYNC")) dut (
    .clk(clk), .rst(rst_s), .clk_en(en_s), .D(d_s), .Q(q_s)
  );
  reg_mux #(.WIDTH(8), .register(1), .TYPE("SYNC")) dut_w (
    .clk(clk), .rst(rst_w), .clk_en(en_w), .D(d_w), .Q(q_w)
  );
  reg_mux #(.WIDTH(18), .register(0), .TYPE("SYNC")) dut_b (
    .clk(clk), .rst(rst_b), .clk_en(en_b), .D(d_b), .Q(q_b)
  );
  reg_mux #(.WIDTH(1), .register(1), .TYPE("ASYNC")) dut_a (
    .clk(clk), .rst(rst_a), .clk_en(en_a), .D(d_a), .Q(q_a)
  );

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the rising edge and sample just after it.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model;
  logic [7:0] rd;
  logic       ren;

  initial begin
    // ---------------- SYNC WIDTH=1: reset with enable -------------------
    @(negedge clk);
    rst_s = 1; d_s = 1; en_s = 1;
    edge_sample();
    chk("rst_with_en", {17'b0, q_s}, 18'd0);
    @(negedge clk);
    rst_s = 0; d_s = 1; en_s = 1;
    edge_sample();
    chk("release_load", {17'b0, q_s}, 18'd1);

    // ---------------- Enable gating -------------------------------------
    @(negedge clk);
    d_s = 0; en_s = 0;
    for (int k = 0; k < 3; k++) begin
      edge_sample();
      chk("en_hold", {17'b0, q_s}, 18'd1);
    end
    @(negedge clk);
    en_s = 1;
    edge_sample();
    chk("en_reload", {17'b0, q_s}, 18'd0);
    @(negedge clk);
    d_s = 1; en_s = 1;
    edge_sample();
    chk("load_one", {17'b0, q_s}, 18'd1);

    // ---------------- Reset priority over disabled enable ---------------
    @(negedge clk);
    rst_s = 1; en_s = 0; d_s = 1;
    #1;
    chk("sync_rst_waits_edge", {17'b0, q_s}, 18'd1);
    edge_sample();
    chk("rst_no_en", {17'b0, q_s}, 18'd0);
    @(negedge clk);
    rst_s = 0; en_s = 0;
    edge_sample();
    chk("release_no_en", {17'b0, q_s}, 18'd0);

    // ---------------- SYNC WIDTH=8: reset then random ------------------
    @(negedge clk);
    rst_w = 1; en_w = 1; d_w = 8'hA5;
    edge_sample();
    chk("w_rst", {10'b0, q_w}, 18'd0);
    model = 8'h00;
    @(negedge clk);
    rst_w = 0;
    for (int i = 0; i < 30; i++) begin
      rd  = 8'($urandom);
      ren = 1'($urandom_range(0, 1));
      d_w = rd; en_w = ren;
      edge_sample();
      if (ren) model = rd;
      chk("w_random", {10'b0, q_w}, {10'b0, model});
      @(negedge clk);
    end
    // Simultaneous reset and enable: reset wins.
    rst_w = 1; en_w = 1; d_w = 8'hFF;
    edge_sample();
    chk("w_rst_and_en", {10'b0, q_w}, 18'd0);
    @(negedge clk);
    rst_w = 0; en_w = 1; d_w = 8'h3C;
    edge_sample();
    chk("w_no_dead_cycle", {10'b0, q_w}, 18'h3C);

    // ---------------- Bypass WIDTH=18 -----------------------------------
    @(negedge clk);
    rst_b = 1; en_b = 0;
    d_b = 18'h3FFFF;
    #1;
    chk("bypass_all_ones", q_b, 18'h3FFFF);
    #2;
    d_b = 18'h00001;
    #1;
    chk("bypass_mid_cycle", q_b, 18'h00001);
    d_b = 18'h2A5A5;
    #0;
    #1;
    chk("bypass_third", q_b, 18'h2A5A5);

    // ---------------- ASYNC WIDTH=1 -------------------------------------
    @(negedge clk);
    rst_a = 1; en_a = 0; d_a = 0;
    edge_sample();
    @(negedge clk);
    rst_a = 0; en_a = 1; d_a = 1;
    edge_sample();
    chk("async_load", {17'b0, q_a}, 18'd1);
    @(negedge clk);
    en_a = 0;
    #1;
    rst_a = 1;
    #1;
    chk("async_clear_midcycle", {17'b0, q_a}, 18'd0);
    #1;
    rst_a = 0;
    edge_sample();
    chk("async_after_pulse", {17'b0, q_a}, 18'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
